// File: rtl/select_encode_seq_if.sv
// Control-unit to register-select/encode bundle: Gr/strobe controls in, one-hot
// register-file enables, selection status and extended immediate out.
interface select_encode_seq_if #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int INSTR_W  = 32,
  parameter int DATA_W   = 32
) ();
  logic                ir_load;
  logic [INSTR_W-1:0]  instr_in;
  logic                Gra;
  logic                Grb;
  logic                Grc;
  logic                Rin;
  logic                Rout;
  logic                BAout;
  logic                zext;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                r0_zero;
  logic [SEL_W-1:0]    sel_index;
  logic                sel_valid;
  logic                sel_err;
  logic [DATA_W-1:0]   C_ext;

  modport master (
    output ir_load, instr_in, Gra, Grb, Grc, Rin, Rout, BAout, zext,
    input  reg_in, reg_out, r0_zero, sel_index, sel_valid, sel_err, C_ext
  );

  modport slave (
    input  ir_load, instr_in, Gra, Grb, Grc, Rin, Rout, BAout, zext,
    output reg_in, reg_out, r0_zero, sel_index, sel_valid, sel_err, C_ext
  );
endinterface

// File: rtl/select_encode_seq.sv
// Register select/encode unit: holds the instruction, remembers the last Gr
// selection, drives one-hot register enables and extends the immediate.
module select_encode_seq #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int INSTR_W  = 32,
  parameter int RA_LSB   = 23,
  parameter int RB_LSB   = 19,
  parameter int RC_LSB   = 15,
  parameter int IMM_W    = 19,
  parameter int DATA_W   = 32
) (
  input logic                clock,
  input logic                clear,
  select_encode_seq_if.slave bus
);

  logic [INSTR_W-1:0]  instr_q;
  logic [SEL_W-1:0]    sel_q;
  logic                sel_valid_q;
  logic                sel_err_q;

  logic                live;
  logic                multi;
  logic [SEL_W-1:0]    live_idx;
  logic [SEL_W-1:0]    eff_idx;
  logic                sel_valid;
  logic [NUM_REGS-1:0] onehot;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                r0_zero;
  logic                unused_instr_bits;

  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                   input logic zero_mode);
    logic signed [IMM_W-1:0] simm;
    simm = imm;
    if (zero_mode) return {{(DATA_W-IMM_W){1'b0}}, imm};
    return {{(DATA_W-IMM_W){simm[IMM_W-1]}}, simm};
  endfunction

  // State: instruction register, held selection, sticky multi-select error
  always_ff @(posedge clock) begin
    if (clear) begin
      instr_q     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      if (bus.ir_load) instr_q <= bus.instr_in;
      if (live) begin
        sel_q       <= live_idx;
        sel_valid_q <= 1'b1;
      end
      if (multi) sel_err_q <= 1'b1;
    end
  end

  // Decode: live selection overrides the held one with zero latency
  always_comb begin
    live     = 1'b0;
    multi    = 1'b0;
    live_idx = instr_q[RC_LSB +: SEL_W];
    case ({bus.Gra, bus.Grb, bus.Grc})
      3'b000:  ;
      3'b100:  begin live = 1'b1; live_idx = instr_q[RA_LSB +: SEL_W]; end
      3'b010:  begin live = 1'b1; live_idx = instr_q[RB_LSB +: SEL_W]; end
      3'b001:  live = 1'b1;
      default: multi = 1'b1;
    endcase
    eff_idx   = live ? live_idx : sel_q;
    sel_valid = live | sel_valid_q;
    onehot    = '0;
    if (sel_valid) onehot[eff_idx] = 1'b1;

    reg_in  = '0;
    reg_out = '0;
    r0_zero = 1'b0;
    if (!clear) begin
      if (bus.Rin) reg_in = onehot;
      if (bus.Rout || bus.BAout) reg_out = onehot;
      // Base addressing treats R0 as constant zero instead of reading it
      if (bus.BAout && sel_valid && (eff_idx == '0)) begin
        reg_out[0] = 1'b0;
        r0_zero    = 1'b1;
      end
    end
  end

  assign unused_instr_bits = ^instr_q;

  assign bus.reg_in    = reg_in;
  assign bus.reg_out   = reg_out;
  assign bus.r0_zero   = r0_zero;
  assign bus.sel_index = eff_idx;
  assign bus.sel_valid = sel_valid;
  assign bus.sel_err   = sel_err_q;
  assign bus.C_ext     = extend_imm(instr_q[IMM_W-1:0], bus.zext);

endmodule
